sar_adc_seq: RTL
================

# sar_adc_seq

Parametrised successive-approximation controller with explicit start/valid handshake, programmable DAC settle time and multi-channel input selection. Sits between the analog front end (comparator, input mux, R2R DAC) and digital consumers. It drives the DAC trial code and mux select, samples the comparator once per bit, and publishes a WIDTH-bit result tagged with its channel.

## Interface
Parameters:
- `WIDTH`, 8: conversion resolution in bits; legal range is 2..16.
- `SETTLE_CYCLES`, 1: wait cycles after each DAC update before `comp_in` is sampled; legal range is 0..15.
- `CH_W`, 2: channel-select width; 2^CH_W channels.

Ports:
- `clk`, in, 1: system clock (5 MHz nominal).
- `reset_in`, in, 1: synchronous, active-high reset.
- `start`, in, 1: conversion request; sampled in IDLE only.
- `ch_sel`, in, CH_W: requested channel; captured when `start` is accepted.
- `comp_in`, in, 1: comparator output; 1 means Vin ≥ DAC voltage.
- `sar_out`, out, WIDTH: DAC trial code.
- `ch_out`, out, CH_W: analog mux select; held stable for the whole conversion.
- `busy`, out, 1: high from the start-accept edge until the completion edge.
- `result`, out, WIDTH: last completed code; held until the next completion.
- `result_ch`, out, CH_W: channel of `result`.
- `valid`, out, 1: one-cycle pulse marking a new `result`.

## Operation
- Reset, applied at any edge while `reset_in` is high, sets all outputs to 0 and the state to IDLE. A conversion in progress is discarded and no `valid` is issued for it.
- The state machine has three states: IDLE, SETTLE and DECIDE.
  - IDLE with `start`=1 → SETTLE. Latch `ch_out`<=`ch_sel`, set bit pointer to WIDTH-1, `sar_out`<=1<<(WIDTH-1), `busy`<=1. If SETTLE_CYCLES=0, go directly to DECIDE.
  - SETTLE counts SETTLE_CYCLES cycles, then → DECIDE.
  - DECIDE samples `comp_in`. If it is 1, the trial bit is kept; if 0, it is cleared.
    - If the bit pointer is greater than 0: set the next-lower bit in `sar_out`, decrement the pointer, and → SETTLE (or stay in DECIDE when SETTLE_CYCLES=0).
    - If the bit pointer is 0: `result`<=final code, `result_ch`<=`ch_out`, `valid`<=1, `sar_out`<=0, `busy`<=0, → IDLE (see Configuration).
- `start` is ignored while `busy`=1. `ch_sel` is ignored except at the accept edge.
- `comp_in` is a don't-care outside DECIDE.
- Code arithmetic uses bitwise set/clear only, so there is no overflow path. A comparator stuck at 1 yields all-ones; stuck at 0 yields 0.

## Timing
- Start is accepted at edge E0. Bit k (k=1..WIDTH, MSB first) is decided at edge E0 + k·(SETTLE_CYCLES+1).
- `valid` rises at edge E0 + WIDTH·(SETTLE_CYCLES+1) and lasts exactly one cycle. For WIDTH=8, SETTLE_CYCLES=1 this is 16 cycles.
- `result` and `result_ch` update on the same edge as `valid`.
- Minimum start-to-start spacing in single-shot mode is WIDTH·(SETTLE_CYCLES+1)+1 cycles. `start` held high on the completion cycle is accepted on the next edge, since the state is IDLE by then.
- `sar_out` changes only on the start-accept edge and on DECIDE edges.

## Configuration
- Feature macro: `SAR_CONTINUOUS_EN`.
  - Defined: on the completion edge, the next conversion starts immediately on channel (`ch_out`+1) mod 2^CH_W.
    - `sar_out`<=MSB trial and `busy` stays 1.
    - `valid` still pulses each conversion; there are no idle cycles between conversions.
    - `start`/`ch_sel` are used only for the first conversion after reset. Only reset stops scanning.
  - Undefined: single-shot behaviour as described in Operation.

## Test plan
- Reset mid-conversion: WIDTH=8, SETTLE=1, start, then assert `reset_in` at cycle 7 → all outputs 0 on the next edge, no `valid`, and the state is IDLE.
- Single-shot, model Vin=0xA5: start with ch_sel=2; `comp_in` = (Vin ≥ `sar_out`) during DECIDE → `valid` at cycle 16, `result`=0xA5, `result_ch`=2, `busy` low on the same edge.
- Extremes: Vin=0 → `result`=0x00; Vin=0xFF → `result`=0xFF. `sar_out` trial sequence for 0xFF is 0x80, 0xC0, …, 0xFF.
- SETTLE_CYCLES=0 and WIDTH=10, Vin=0x2F3 → `valid` at cycle 10, `result`=0x2F3. `start` pulsed mid-conversion is ignored, with no second `valid`.
- `SAR_CONTINUOUS_EN`, CH_W=2, start on ch 3 → `valid` every 16 cycles with `result_ch` 3, 0, 1, 2, 3. `busy` stays high throughout.

Source files
------------

// File: rtl/sar_adc_seq.sv
// Successive-approximation ADC sequencer: MSB-first trial codes, programmable DAC settle, channel-tagged result.
// Optional `SAR_CONTINUOUS_EN: back-to-back conversions that round-robin the channels after the first start.
module sar_adc_seq #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int CH_W          = 2
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             start,
  input  logic [CH_W-1:0]  ch_sel,
  input  logic             comp_in,
  output logic [WIDTH-1:0] sar_out,
  output logic [CH_W-1:0]  ch_out,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic [CH_W-1:0]  result_ch,
  output logic             valid
);

  localparam int                PTR_W       = $clog2(WIDTH);
  localparam logic [PTR_W-1:0]  MSB_PTR     = PTR_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]  MSB_CODE    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [3:0]        SETTLE_LOAD = 4'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETTLE, DECIDE} state_t;

  // With no settle time every DAC update goes straight to a decision.
  localparam state_t WAIT_STATE = (SETTLE_CYCLES == 0) ? DECIDE : SETTLE;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] sar_q, sar_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CH_W-1:0]  result_ch_q, result_ch_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] code;
  logic [PTR_W-1:0] ptr_m1;

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      sar_q       <= '0;
      ch_q        <= '0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      result_ch_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      sar_q       <= sar_d;
      ch_q        <= ch_d;
      busy_q      <= busy_d;
      result_q    <= result_d;
      result_ch_q <= result_ch_d;
      valid_q     <= valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    sar_d       = sar_q;
    ch_d        = ch_q;
    busy_d      = busy_q;
    result_d    = result_q;
    result_ch_d = result_ch_q;
    valid_d     = 1'b0;
    code        = sar_q;
    ptr_m1      = ptr_q - 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          ch_d    = ch_sel;
          ptr_d   = MSB_PTR;
          sar_d   = MSB_CODE;
          busy_d  = 1'b1;
          cnt_d   = SETTLE_LOAD;
          state_d = WAIT_STATE;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) state_d = DECIDE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      DECIDE: begin
        // Comparator low means the DAC overshot Vin, so drop the trial bit.
        if (!comp_in) code[ptr_q] = 1'b0;
        if (ptr_q != '0) begin
          code[ptr_m1] = 1'b1;
          sar_d        = code;
          ptr_d        = ptr_m1;
          cnt_d        = SETTLE_LOAD;
          state_d      = WAIT_STATE;
        end else begin
          result_d    = code;
          result_ch_d = ch_q;
          valid_d     = 1'b1;
`ifdef SAR_CONTINUOUS_EN
          sar_d       = MSB_CODE;
          ch_d        = ch_q + 1'b1;
          ptr_d       = MSB_PTR;
          cnt_d       = SETTLE_LOAD;
          state_d     = WAIT_STATE;
`else
          sar_d       = '0;
          busy_d      = 1'b0;
          state_d     = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sar_out   = sar_q;
  assign ch_out    = ch_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign result_ch = result_ch_q;
  assign valid     = valid_q;

endmodule
